// File: rtl/qspi_mem_responder.sv
// QSPI quad-mode memory responder: serves a small byte memory to a QSPI initiator.
// Optional write protect enabled by defining QSPI_RESP_WP_EN.
module qspi_mem_responder #(
  parameter int ADDR_BITS    = 6,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic [3:0]           io_in,
  output logic [3:0]           io_out,
  output logic [3:0]           io_oe,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  input  logic                 wp,
  output logic                 busy,
  output logic                 byte_wr,
  output logic                 cmd_err,
  output logic                 wp_hit
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] DUMMY  = 3'd3;
  localparam logic [2:0] READ   = 3'd4;
  localparam logic [2:0] WRITE  = 3'd5;
  localparam logic [2:0] IGNORE = 3'd6;

  localparam logic [7:0] CMD_RD = 8'hEB;
  localparam logic [7:0] CMD_WR = 8'h38;

  localparam logic [ADDR_BITS-1:0] PTR_ONE =
    {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [7:0] mem_q [DEPTH];

  logic [2:0]           sclk_q, cs_q;
  logic [2:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [23:0]          sh_q, sh_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                 rd_q, rd_d;
  logic                 lo_q, lo_d;
  logic [3:0]           out_q, out_d;
  logic                 oe_q, oe_d;
  logic                 bwr_q, bwr_d;
  logic                 err_q, err_d;
  logic                 wph_q, wph_d;

  logic                 mem_we;
  logic [7:0]           mem_wdata;
  logic [7:0]           mem_rd;
  logic [23:0]          nib;
  logic [ADDR_BITS-1:0] ptr_inc;
  logic                 sclk_rise, sclk_fall;
  logic                 cs_rise, cs_fall;

  // Bit 0/1 form the synchronizer, bit 2 is the edge-history flop.
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];

  assign nib       = {sh_q[19:0], io_in};
  assign mem_wdata = {sh_q[3:0], io_in};
  assign mem_rd    = mem_q[ptr_q];
  assign ptr_inc   = ptr_q + PTR_ONE;

  assign io_out  = out_q;
  assign io_oe   = {4{oe_q}};
  assign busy    = (state_q != IDLE);
  assign byte_wr = bwr_q;
  assign cmd_err = err_q;
  assign wp_hit  = wph_q;

`ifdef QSPI_RESP_WP_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, sh_q[23:20]};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, sh_q[23:20], wp};
`endif

  // Protocol FSM: acts only on synchronized sclk/cs_n edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    rd_d    = rd_q;
    lo_d    = lo_q;
    out_d   = out_q;
    oe_d    = oe_q;
    bwr_d   = 1'b0;
    err_d   = 1'b0;
    wph_d   = 1'b0;
    mem_we  = 1'b0;
    if (cs_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = CMD;
            cnt_d   = 8'd0;
            sh_d    = 24'd0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            sh_d = nib;
            if (cnt_q == 8'd1) begin
              cnt_d = 8'd0;
              if (nib[7:0] == CMD_RD) begin
                rd_d    = 1'b1;
                state_d = ADDR;
              end else if (nib[7:0] == CMD_WR) begin
                rd_d    = 1'b0;
                state_d = ADDR;
              end else begin
                err_d   = 1'b1;
                state_d = IGNORE;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            sh_d = nib;
            if (cnt_q == 8'd5) begin
              cnt_d = 8'd0;
              ptr_d = nib[ADDR_BITS-1:0];
              lo_d  = 1'b0;
              if (!rd_q) begin
                state_d = WRITE;
              end else if (DUMMY_CYCLES == 0) begin
                state_d = READ;
                oe_d    = 1'b1;
              end else begin
                state_d = DUMMY;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        DUMMY: begin
          if (sclk_rise) begin
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = 8'd0;
              state_d = READ;
              oe_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        READ: begin
          if (sclk_fall) begin
            if (!lo_q) begin
              out_d = mem_rd[7:4];
              lo_d  = 1'b1;
            end else begin
              out_d = mem_rd[3:0];
              lo_d  = 1'b0;
              ptr_d = ptr_inc;
            end
          end
        end
        WRITE: begin
          if (sclk_rise) begin
            sh_d = nib;
            if (!lo_q) begin
              lo_d = 1'b1;
            end else begin
              lo_d  = 1'b0;
              ptr_d = ptr_inc;
`ifdef QSPI_RESP_WP_EN
              if (wp) begin
                wph_d = 1'b1;
              end else begin
                mem_we = 1'b1;
                bwr_d  = 1'b1;
              end
`else
              mem_we = 1'b1;
              bwr_d  = 1'b1;
`endif
            end
          end
        end
        IGNORE: begin
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // State, synchronizers and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q  <= 3'b000;
      cs_q    <= 3'b000;
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sh_q    <= 24'd0;
      ptr_q   <= '0;
      rd_q    <= 1'b0;
      lo_q    <= 1'b0;
      out_q   <= 4'd0;
      oe_q    <= 1'b0;
      bwr_q   <= 1'b0;
      err_q   <= 1'b0;
      wph_q   <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      cs_q    <= {cs_q[1:0], cs_n};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      bwr_q   <= bwr_d;
      err_q   <= err_d;
      wph_q   <= wph_d;
    end
  end

  // Byte memory: QSPI writes, or backdoor loads while idle; never reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[ptr_q] <= mem_wdata;
    end else if (load_en && !busy) begin
      mem_q[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Self-checking bench for qspi_mem_responder.
// Bench acts as the QSPI initiator with directed vectors.
module tb_qspi_mem_responder;

  localparam int AB = 6;
  localparam int DC = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic [3:0]    io_in = 4'd0;
  logic [3:0]    io_out;
  logic [3:0]    io_oe;
  logic          load_en = 1'b0;
  logic [AB-1:0] load_addr = '0;
  logic [7:0]    load_data = 8'd0;
  logic          wp = 1'b0;
  logic          busy, byte_wr, cmd_err, wp_hit;

  qspi_mem_responder #(.ADDR_BITS(AB), .DUMMY_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .wp(wp), .busy(busy),
    .byte_wr(byte_wr), .cmd_err(cmd_err), .wp_hit(wp_hit)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int bwr_cnt = 0;
  int err_cnt = 0;
  int wph_cnt = 0;
  int oe_cnt = 0;
  logic last_oe;

  always @(posedge clk) begin
    bwr_cnt <= bwr_cnt + int'(byte_wr);
    err_cnt <= err_cnt + int'(cmd_err);
    wph_cnt <= wph_cnt + int'(wp_hit);
    oe_cnt  <= oe_cnt + int'(io_oe != 4'd0);
  end

  typedef struct {
    logic [AB-1:0] la;
    logic [7:0]    ld;
    logic [23:0]   ra;
    logic [7:0]    exp;
  } rd_vec_t;

  rd_vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [AB-1:0] a, input logic [7:0] d);
    load_addr = a;
    load_data = d;
    load_en = 1'b1;
    #10;
    load_en = 1'b0;
  endtask

  task automatic nib(input logic [3:0] d, output logic [3:0] q);
    io_in = d;
    #50;
    sclk = 1'b1;
    q = io_out;
    last_oe = io_oe[0];
    #50;
    sclk = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #50;
  endtask

  task automatic cs_high(output int cyc);
    #50;
    cs_n = 1'b1;
    cyc = 0;
    while (busy && cyc < 20) begin
      #10;
      cyc++;
    end
    #50;
  endtask

  task automatic send_addr(input logic [23:0] a, output int oe_hi);
    logic [3:0] q;
    for (int i = 0; i < 6; i++) begin
      nib(a[23-4*i -: 4], q);
      oe_hi += int'(last_oe);
    end
  endtask

  task automatic qspi_read(input logic [23:0] a, input int nn,
                           output logic [15:0] d, output int pre_oe,
                           output int dat_oe_lo, output int cyc);
    logic [3:0] q;
    pre_oe = 0;
    dat_oe_lo = 0;
    d = 16'd0;
    cs_low();
    nib(4'hE, q); pre_oe += int'(last_oe);
    nib(4'hB, q); pre_oe += int'(last_oe);
    send_addr(a, pre_oe);
    for (int i = 0; i < DC; i++) begin
      nib(4'h0, q);
      pre_oe += int'(last_oe);
    end
    for (int i = 0; i < nn; i++) begin
      nib(4'h0, q);
      d = {d[11:0], q};
      dat_oe_lo += int'(!last_oe);
    end
    cs_high(cyc);
  endtask

  task automatic qspi_write(input logic [23:0] a, input logic [15:0] w,
                            input int nn);
    logic [3:0] q;
    int oh;
    int cyc;
    oh = 0;
    cs_low();
    nib(4'h3, q);
    nib(4'h8, q);
    send_addr(a, oh);
    for (int i = 0; i < nn; i++) nib(w[15-4*i -: 4], q);
    cs_high(cyc);
  endtask

  task automatic rd_byte(input logic [23:0] a, output logic [7:0] b);
    logic [15:0] d;
    int p, l, c;
    qspi_read(a, 2, d, p, l, c);
    b = d[7:0];
  endtask

  initial begin
    logic [15:0] d16;
    logic [7:0]  b;
    logic [3:0]  q;
    int p, l, c, base, base2, base3;

    vecs[0] = '{6'h10, 8'hA5, 24'h000010, 8'hA5};
    vecs[1] = '{6'h11, 8'h3C, 24'h000011, 8'h3C};
    vecs[2] = '{6'h00, 8'h5A, 24'hFFFFC0, 8'h5A};
    vecs[3] = '{6'h2A, 8'hF0, 24'h12346A, 8'hF0};
    vecs[4] = '{6'h3F, 8'h81, 24'h00007F, 8'h81};

    #35;
    chk("rst_io_oe", {28'd0, io_oe}, 32'd0);
    chk("rst_io_out", {28'd0, io_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_byte_wr", {31'd0, byte_wr}, 32'd0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    chk("rst_wp_hit", {31'd0, wp_hit}, 32'd0);
    rst = 1'b0;
    #50;

    foreach (vecs[i]) load(vecs[i].la, vecs[i].ld);
    foreach (vecs[i]) begin
      rd_byte(vecs[i].ra, b);
      chk($sformatf("tbl_rd%0d", i), {24'd0, b}, {24'd0, vecs[i].exp});
    end

    qspi_read(24'h000010, 4, d16, p, l, c);
    chk("burst_rd", {16'd0, d16}, 32'h0000A53C);
    chk("oe_before_read", p, 0);
    chk("oe_low_in_read", l, 0);
    chk("busy_fall_2_3", {31'd0, (c >= 2 && c <= 3)}, 32'd1);
    chk("oe_after_end", {28'd0, io_oe}, 32'd0);

    base = bwr_cnt;
    qspi_write(24'h00003F, 16'h1122, 4);
    chk("wr_pulses", bwr_cnt - base, 2);
    qspi_read(24'h00003F, 4, d16, p, l, c);
    chk("wr_readback_wrap", {16'd0, d16}, 32'h00001122);

    base = err_cnt;
    base2 = oe_cnt;
    cs_low();
    nib(4'h9, q);
    nib(4'hF, q);
    for (int i = 0; i < 10; i++) nib(4'h0, q);
    cs_high(c);
    chk("cmd_err_pulse", err_cnt - base, 1);
    chk("cmd_err_no_oe", oe_cnt - base2, 0);
    rd_byte(24'h000010, b);
    chk("rd_after_err", {24'd0, b}, 32'hA5);

    load(6'h05, 8'h99);
    base = bwr_cnt;
    cs_low();
    nib(4'h3, q);
    nib(4'h8, q);
    chk("busy_in_xfer", {31'd0, busy}, 32'd1);
    load(6'h05, 8'hEE);
    p = 0;
    send_addr(24'h000005, p);
    nib(4'h7, q);
    cs_high(c);
    chk("partial_no_wr", bwr_cnt - base, 0);
    rd_byte(24'h000005, b);
    chk("partial_mem5", {24'd0, b}, 32'h99);

    cs_low();
    nib(4'hE, q);
    nib(4'hB, q);
    p = 0;
    send_addr(24'h000010, p);
    for (int i = 0; i < DC; i++) nib(4'h0, q);
    for (int i = 0; i < 3; i++) nib(4'h0, q);
    rst = 1'b1;
    #10;
    chk("rst_mid_oe", {28'd0, io_oe}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    base2 = oe_cnt;
    base3 = 0;
    nib(4'hE, q);
    nib(4'hB, q);
    for (int i = 0; i < 12; i++) begin
      nib(4'h0, q);
      base3 += int'(busy);
    end
    chk("post_rst_idle_busy", base3, 0);
    chk("post_rst_no_oe", oe_cnt - base2, 0);
    cs_n = 1'b1;
    #100;
    rd_byte(24'h000011, b);
    chk("rd_after_rst", {24'd0, b}, 32'h3C);

    load(6'h08, 8'h44);
    base = bwr_cnt;
    base2 = wph_cnt;
    wp = 1'b1;
    qspi_write(24'h000008, 16'h7700, 2);
    wp = 1'b0;
    rd_byte(24'h000008, b);
`ifdef QSPI_RESP_WP_EN
    chk("wp_hit_pulse", wph_cnt - base2, 1);
    chk("wp_no_byte_wr", bwr_cnt - base, 0);
    chk("wp_mem8", {24'd0, b}, 32'h44);
`else
    chk("wp_hit_tied", wph_cnt - base2, 0);
    chk("wp_ignored_wr", bwr_cnt - base, 1);
    chk("wp_ignored_mem8", {24'd0, b}, 32'h77);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
- Synthesizable QSPI target that answers the CPU's QSPI initiator.
- Used as an on-chip or FPGA-side stand-in for the external flash/PSRAM during bring-up and co-simulation.
- Oversamples SCLK/CS on the system clock, decodes quad-mode read/write commands, and serves a small internal byte memory.
- Memory is also preloadable through a backdoor port.

Parameters:
- ADDR_BITS, 6: internal memory depth = 2**ADDR_BITS bytes; the 24-bit bus address is taken modulo depth.
- DUMMY_CYCLES, 6: SCLK rising edges between the last address nibble and the first read-data nibble.

Ports:
- clk  in  1  system clock; must be at least 4x SCLK frequency.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  QSPI clock from the initiator (asynchronous to clk).
- cs_n  in  1  chip select, active low.
- io_in  in  4  QSPI data lines sampled from the initiator.
- io_out  out  4  QSPI data lines driven by the responder.
- io_oe  out  4  output enable per line (all bits equal).
- load_en  in  1  backdoor byte write strobe.
- load_addr  in  ADDR_BITS  backdoor address.
- load_data  in  8  backdoor data.
- wp  in  1  write protect (used only with QSPI_RESP_WP_EN).
- busy  out  1  high while a transaction is active (cs_n synchronized low).
- byte_wr  out  1  one-clk pulse per byte committed by a QSPI write.
- cmd_err  out  1  one-clk pulse when an unknown command byte completes.
- wp_hit  out  1  one-clk pulse when a protected write byte is dropped (0 without macro).

Behaviour:
- Synchronization and edge detection
  - sclk and cs_n each pass through a 2-flop synchronizer plus a history flop for edge detection.
  - All protocol actions occur on the clk cycle where a synchronized edge is detected.
  - The initiator drives on SCLK falling and samples on SCLK rising; the responder does the same.
  - Nibble order is MSB first; every phase is 4 bits per SCLK.
- Reset
  - State=IDLE; io_out=0, io_oe=0, busy=0, byte_wr=0, cmd_err=0, wp_hit=0.
  - Counters and shift registers are cleared.
  - Memory contents are NOT reset.
- States: IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
- IDLE -> CMD: on synchronized cs_n falling; busy=1.
- CMD: 2 rising edges shift in 8 bits.
  - 0xEB -> ADDR (read).
  - 0x38 -> ADDR (write).
  - Any other value -> cmd_err pulse, then IGNORE.
- ADDR: 6 rising edges shift in 24 bits; the low ADDR_BITS bits become the pointer.
  - Read -> DUMMY; write -> WRITE.
- DUMMY: count DUMMY_CYCLES rising edges, then READ.
  - If DUMMY_CYCLES=0, go directly to READ.
- READ:
  - io_oe=1 from entry until the transaction ends.
  - On each falling edge, drive the next nibble: high nibble of mem[ptr], then low nibble.
  - After the low nibble, ptr = (ptr+1) mod depth.
  - The first nibble is driven on the falling edge after the last DUMMY (or ADDR) rising edge.
  - io_out holds its value between edges.
- WRITE:
  - Each 2 rising edges assemble one byte.
  - On the second nibble, write mem[ptr], pulse byte_wr, and set ptr = (ptr+1) mod depth.
  - io_oe stays 0.
- IGNORE: hold io_oe=0 until the end of the transaction.
- End of transaction: synchronized cs_n rising in any state -> IDLE next cycle.
  - io_oe=0 and busy=0 in that cycle.
  - A partial write nibble is discarded.
  - A read may end mid-byte.
- Backdoor load: load_en is honoured only when busy=0, writing mem[load_addr]=load_data in that cycle; while busy=1 it is ignored.
- Simultaneous edges: a cs_n rising edge takes precedence over an sclk edge in the same clk cycle.
- Reset asserted mid-transaction forces IDLE regardless of cs_n.
  - After reset deassertion with cs_n still low, the responder waits for a fresh cs_n falling edge and sits in IDLE.
- Address wrap: a burst past depth-1 continues at 0.

Optional Feature:
- Macro: QSPI_RESP_WP_EN.
- Defined: while wp=1 at the commit cycle, WRITE bytes are not stored.
  - wp_hit pulses instead of byte_wr.
  - ptr still increments.
- Not defined: wp is ignored and wp_hit is tied 0.

Test Plan:
- Preload via backdoor: mem[0x10]=0xA5, mem[0x11]=0x3C. Quad read 0xEB, addr 0x000010, 6 dummy, 4 data nibbles -> initiator samples A,5,3,C; io_oe high only in READ; busy low 2-3 clk after cs_n high.
- Quad write 0x38 to addr 0x00003F with data 0x11,0x22 -> two byte_wr pulses. Backdoor-independent readback at 0x3F gives 0x11; readback at 0x00 (wrap) gives 0x22.
- Command 0x9F -> one cmd_err pulse; io_oe stays 0 for the whole cs_n-low window; the next valid read succeeds.
- Write 0x38, addr 0x5, then 1 nibble then cs_n high -> no byte_wr and mem[5] unchanged; load_en pulsed while busy=1 does not modify memory.
- rst asserted during READ at byte 2 -> io_oe=0, busy=0 next clk. With cs_n still low, no response until cs_n toggles high then low.
- With QSPI_RESP_WP_EN and wp=1, write 0x77 to addr 0x08 -> wp_hit pulse, no byte_wr, mem[8] unchanged.
